// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding, the counter sizing rule and width-parametrised sign helpers.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Iteration counter width; sized for WIDTH+1 so the last count never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Static helpers parametrised on operand width; never instantiated.
  virtual class mult_fn #(parameter int W = 32);
    static function logic [W-1:0] negate(input logic [W-1:0] x);
      return ~x + W'(1);
    endfunction

    static function logic [W-1:0] magnitude(input logic [W-1:0] x);
      return x[W-1] ? negate(x) : x;
    endfunction
  endclass

endpackage

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: magnitude/operand registers, WIDTH+1-bit adder,
// {carry, acc_hi, multiplier} shift register and final sign fix into the product register.
module mult_seq_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               add,
  input  logic               shr,
  input  logic               write,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_hi;
  logic             neg;
  logic [WIDTH:0]   sum;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sum = {1'b0, acc_hi};
    if (add && mplier[0]) begin
      sum = {1'b0, acc_hi} + {1'b0, mcand};
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  // NOTE: all datapath registers are cleared on reset so an aborted operation leaves no stale product.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (load) begin
        mcand  <= signed_mode ? mult_fn#(WIDTH)::magnitude(a) : a;
        mplier <= signed_mode ? mult_fn#(WIDTH)::magnitude(b) : b;
        acc_hi <= '0;
        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (shr) begin
        // The carry out of the add becomes the new MSB of acc_hi.
        acc_hi <= sum[WIDTH:1];
        mplier <= {sum[0], mplier[WIDTH-1:1]};
      end
      if (write) begin
        product <= neg ? mult_fn#(2*WIDTH)::negate({acc_hi, mplier}) : {acc_hi, mplier};
      end
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier top: start/busy/done handshake FSM and iteration counter.
// One operation at a time; product holds until the next accepted start.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          load, add, shr, write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt <= '0;
      end else if (state == CALC && cnt != LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    add       = 1'b0;
    shr       = 1'b0;
    write     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        add = 1'b1;
        shr = 1'b1;
        if (cnt == LAST) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        write     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .add         (add),
    .shr         (shr),
    .write       (write),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .product     (product)
  );

endmodule
